// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state type and counter sizing shared by the serial adder files
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int CNT_W = $clog2(DEF_WIDTH + 1);

    // Bit-counter width for an arbitrary operand width
    function automatic int cnt_w(int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// fa_bit: combinational one-bit full adder cell driven by the serial sequencer
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder around one full-adder cell; SERIAL_ADDER_SUB_EN adds a subtract port
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] b_ld;
    logic             c_ld;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             co;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_ld = sub ? ~b : b;
    assign c_ld = cin | sub;
`else
    assign b_ld = b;
    assign c_ld = cin;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    fa_bit u_fa (
        .a (a_sh[0]),
        .b (b_sh[0]),
        .c (carry),
        .s (s),
        .co(co)
    );

    // Sequencer: load operands, shift one bit per cycle through the cell, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sum   <= '0;
            cout  <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state <= RUN;
                    a_sh  <= a;
                    b_sh  <= b_ld;
                    carry <= c_ld;
                    cnt   <= '0;
                end
                RUN: begin
                    carry <= co;
                    sum   <= (sum >> 1) | (WIDTH'(s) << (WIDTH - 1));
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        cout  <= co;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
